// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and the
// number of idle cycles tolerated before a start strobe is repeated.
package mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DELIVER   = 3'd4
    } mult_state_t;

    localparam int unsigned TIMEOUT_CYC = 4;
    localparam int          TO_W        = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection: searches upward from ptr+1
// (wrapping) and returns the first requester found as one-hot plus index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0] cand_s;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        cand_s = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand_s = ID_W'((int'(ptr) + off) % N_REQ);
            idx    = req[cand_s] ? cand_s : idx;
            found  = found | req[cand_s];
        end
        gnt = found ? (ONE << idx) : '0;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates N_REQ requesters onto one shared 8x8 sequential multiplier,
// one operation in flight, results tagged with the owning requester ID.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*8-1:0] a_bi,
    input  logic [N_REQ*8-1:0] b_bi,
    output logic [N_REQ-1:0]   gnt_o,
    output logic               res_valid_o,
    output logic [ID_W-1:0]    res_id_o,
    output logic [15:0]        res_y_bo,
    output logic               busy_o,
    output logic               mult_start_o,
    output logic [7:0]         mult_a_bo,
    output logic [7:0]         mult_b_bo,
    input  logic               mult_busy_i,
    input  logic [15:0]        mult_y_bi
);

    mult_state_t       state_r;
    logic [ID_W-1:0]   id_r;
    logic [ID_W-1:0]   last_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic [N_REQ-1:0]  gnt_r;
    logic              res_valid_r;
    logic [ID_W-1:0]   res_id_r;
    logic [15:0]       res_y_r;
    logic              busy_r;
    logic              start_r;
    logic [7:0]        a_r;
    logic [7:0]        b_r;

    logic [N_REQ-1:0]  pick_gnt_s;
    logic [ID_W-1:0]   pick_idx_s;
    logic              pick_found_s;
    logic [7:0]        a_arr_s [N_REQ];
    logic [7:0]        b_arr_s [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_slice
        assign a_arr_s[k] = a_bi[k*8 +: 8];
        assign b_arr_s[k] = b_bi[k*8 +: 8];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req   (req_i),
        .ptr   (last_r),
        .gnt   (pick_gnt_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Control FSM; every output is a register so pulses are glitch-free.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= ST_IDLE;
            id_r        <= '0;
            last_r      <= ID_W'(N_REQ - 1);
            to_cnt_r    <= '0;
            gnt_r       <= '0;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            res_y_r     <= 16'd0;
            busy_r      <= 1'b0;
            start_r     <= 1'b0;
            a_r         <= 8'd0;
            b_r         <= 8'd0;
        end else begin
            gnt_r       <= '0;
            start_r     <= 1'b0;
            res_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A multiplier still busy from a discarded job blocks issue.
                    if (pick_found_s && !mult_busy_i) begin
                        gnt_r   <= pick_gnt_s;
                        id_r    <= pick_idx_s;
                        a_r     <= a_arr_s[pick_idx_s];
                        b_r     <= b_arr_s[pick_idx_s];
                        state_r <= ST_ISSUE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    start_r  <= 1'b1;
                    to_cnt_r <= '0;
                    state_r  <= ST_WAIT_BUSY;
                    busy_r   <= 1'b1;
                end
                ST_WAIT_BUSY: begin
                    busy_r <= 1'b1;
                    if (mult_busy_i) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (to_cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    busy_r <= 1'b1;
                    if (!mult_busy_i) begin
                        res_y_r     <= mult_y_bi;
                        res_valid_r <= 1'b1;
                        res_id_r    <= id_r;
                        state_r     <= ST_DELIVER;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_DELIVER: begin
                    last_r  <= id_r;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_r;
    assign res_valid_o  = res_valid_r;
    assign res_id_o     = res_id_r;
    assign res_y_bo     = res_y_r;
    assign busy_o       = busy_r;
    assign mult_start_o = start_r;
    assign mult_a_bo    = a_r;
    assign mult_b_bo    = b_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural sequential
// multiplier and a round-robin reference model.
module tb_mult_arbiter;

    localparam int N = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic [3:0]  req_i = 4'd0;
    logic [31:0] a_bi = 32'd0;
    logic [31:0] b_bi = 32'd0;
    logic [3:0]  gnt_o;
    logic        res_valid_o;
    logic [1:0]  res_id_o;
    logic [15:0] res_y_bo;
    logic        busy_o;
    logic        mult_start_o;
    logic [7:0]  mult_a_bo;
    logic [7:0]  mult_b_bo;
    logic        mult_busy_i;
    logic [15:0] mult_y_bi;

    always #5 clk_i = ~clk_i;

    mult_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .a_bi         (a_bi),
        .b_bi         (b_bi),
        .gnt_o        (gnt_o),
        .res_valid_o  (res_valid_o),
        .res_id_o     (res_id_o),
        .res_y_bo     (res_y_bo),
        .busy_o       (busy_o),
        .mult_start_o (mult_start_o),
        .mult_a_bo    (mult_a_bo),
        .mult_b_bo    (mult_b_bo),
        .mult_busy_i  (mult_busy_i),
        .mult_y_bi    (mult_y_bi)
    );

    // Multiplier model: a start begins mul_lat busy cycles; ignored starts mimic a stuck unit.
    logic        m_busy = 1'b0;
    logic [15:0] m_y = 16'd0;
    logic [7:0]  m_pa = 8'd0;
    logic [7:0]  m_pb = 8'd0;
    int          m_cnt = 0;
    int          ignored_r = 0;
    int          ignore_target = 0;
    int          mul_lat = 8;

    assign mult_busy_i = m_busy;
    assign mult_y_bi   = m_y;

    always @(posedge clk_i) begin
        if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_y    <= 16'(m_pa) * 16'(m_pb);
            end
            m_cnt <= m_cnt - 1;
        end else if (mult_start_o) begin
            if (ignored_r < ignore_target) begin
                ignored_r <= ignored_r + 1;
            end else begin
                m_busy <= 1'b1;
                m_cnt  <= mul_lat;
                m_pa   <= mult_a_bo;
                m_pb   <= mult_b_bo;
            end
        end
    end

    typedef struct {
        int         g;
        logic [3:0] gv;
        int         id;
        int         y;
        int         lat;
        int         starts;
        int         gap;
        bit         stable;
        int         extra;
        bit         ok;
    } op_res_t;

    op_res_t     r_op;
    logic [7:0]  opa [4];
    logic [7:0]  opb [4];
    int          checks = 0;
    int          passed = 0;
    int          last_ref = 3;

    function automatic int rr_ref(input logic [3:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            if (((r >> ((last + off) % N)) & 4'd1) != 4'd0) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic set_ops();
        a_bi = {opa[3], opa[2], opa[1], opa[0]};
        b_bi = {opb[3], opb[2], opb[1], opb[0]};
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        req_i  = 4'd0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        last_ref = 3;
    endtask

    task automatic wait_grant(output int idx, output bit ok);
        idx = -1;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (gnt_o != 4'd0) begin
                for (int k = 0; k < N; k++) if (((gnt_o >> k) & 4'd1) != 4'd0) idx = k;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Follows a granted operation until its result, recording what happened.
    task automatic finish_op(input int idx, input bit keep);
        logic [7:0] ea, eb;
        int s1;
        s1 = -1;
        ea = opa[idx];
        eb = opb[idx];
        if (!keep) req_i = req_i & ~(4'd1 << idx);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            r_op.lat++;
            if (mult_start_o) begin
                r_op.starts++;
                if (s1 < 0) s1 = r_op.lat;
                else if (r_op.gap < 0) r_op.gap = r_op.lat - s1;
            end
            if (gnt_o != 4'd0) r_op.extra++;
            if (res_valid_o) begin
                r_op.id = int'(res_id_o);
                r_op.y  = int'(res_y_bo);
                r_op.ok = 1'b1;
                break;
            end
            if (mult_a_bo !== ea || mult_b_bo !== eb) r_op.stable = 1'b0;
        end
    endtask

    task automatic run_op(input bit keep);
        int idx;
        bit gok;
        r_op = '{g: -1, gv: 4'd0, id: -1, y: -1, lat: 0, starts: 0, gap: -1,
                 stable: 1'b1, extra: 0, ok: 1'b0};
        wait_grant(idx, gok);
        r_op.g  = idx;
        r_op.gv = gnt_o;
        if (gok) finish_op(idx, keep);
    endtask

    task automatic test_reset();
        req_i = 4'd0;
        @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        checks++; if (gnt_o !== 4'd0) $display("FAIL reset_gnt got=%b exp=0000", gnt_o); else passed++;
        checks++; if (res_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", res_valid_o); else passed++;
        checks++; if (res_id_o !== 2'd0) $display("FAIL reset_id got=%0d exp=0", res_id_o); else passed++;
        checks++; if (res_y_bo !== 16'd0) $display("FAIL reset_y got=%0d exp=0", res_y_bo); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else passed++;
        checks++; if (mult_start_o !== 1'b0) $display("FAIL reset_start got=%b exp=0", mult_start_o); else passed++;
        checks++; if ({mult_a_bo, mult_b_bo} !== 16'd0) $display("FAIL reset_ops got=%h exp=0000", {mult_a_bo, mult_b_bo}); else passed++;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || gnt_o !== 4'd0) $display("FAIL reset_idle got=%b/%b exp=0/0000", busy_o, gnt_o); else passed++;
        last_ref = 3;
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < N; k++) begin opa[k] = 8'd0; opb[k] = 8'd0; end
        opa[0] = 8'd12; opb[0] = 8'd13;
        set_ops();
        mul_lat = 8;
        req_i = 4'b0001;
        run_op(1'b0);
        checks++; if (r_op.gv !== 4'b0001) $display("FAIL single_gnt got=%b exp=0001", r_op.gv); else passed++;
        checks++; if (!r_op.ok) $display("FAIL single_done got=0 exp=1"); else passed++;
        checks++; if (r_op.lat != 11) $display("FAIL single_latency got=%0d exp=11", r_op.lat); else passed++;
        checks++; if (r_op.id != 0) $display("FAIL single_id got=%0d exp=0", r_op.id); else passed++;
        checks++; if (r_op.y != 156) $display("FAIL single_y got=%0d exp=156", r_op.y); else passed++;
        checks++; if (!r_op.stable) $display("FAIL single_ops_stable got=0 exp=1"); else passed++;
        checks++; if (r_op.starts != 1) $display("FAIL single_starts got=%0d exp=1", r_op.starts); else passed++;
        last_ref = 0;
        @(negedge clk_i);
        checks++; if (res_valid_o !== 1'b0) $display("FAIL single_valid_pulse got=%b exp=0", res_valid_o); else passed++;
        checks++; if (res_y_bo !== 16'd156) $display("FAIL single_y_hold got=%0d exp=156", res_y_bo); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL single_busy_idle got=%b exp=0", busy_o); else passed++;
        repeat (3) @(negedge clk_i);
        checks++; if (gnt_o !== 4'd0) $display("FAIL single_no_regrant got=%b exp=0000", gnt_o); else passed++;
    endtask

    task automatic test_all_four();
        do_reset();
        for (int k = 0; k < N; k++) begin opa[k] = 8'(k + 2); opb[k] = 8'd10; end
        set_ops();
        mul_lat = 8;
        req_i = 4'b1111;
        for (int k = 0; k < N; k++) begin
            run_op(1'b0);
            checks++; if (r_op.g != k) $display("FAIL all4_grant got=%0d exp=%0d", r_op.g, k); else passed++;
            checks++; if (r_op.id != k) $display("FAIL all4_id got=%0d exp=%0d", r_op.id, k); else passed++;
            checks++; if (r_op.y != (k + 2) * 10) $display("FAIL all4_y got=%0d exp=%0d", r_op.y, (k + 2) * 10); else passed++;
            last_ref = k;
        end
        req_i = 4'd0;
    endtask

    task automatic test_fairness();
        int cnt [4];
        logic [3:0] seen;
        int exp;
        do_reset();
        for (int k = 0; k < N; k++) begin
            opa[k] = 8'($urandom_range(0, 255));
            opb[k] = 8'($urandom_range(0, 255));
            cnt[k] = 0;
        end
        set_ops();
        mul_lat = 3;
        seen = 4'd0;
        req_i = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            if (n == 4) seen = 4'd0;
            exp = rr_ref(4'b1111, last_ref);
            if (n == 7) begin
                run_op(1'b1);
                req_i = 4'd0;
            end else begin
                run_op(1'b1);
            end
            checks++; if (r_op.id != exp) $display("FAIL fair_id got=%0d exp=%0d", r_op.id, exp); else passed++;
            checks++; if (r_op.y != int'(opa[exp]) * int'(opb[exp])) $display("FAIL fair_y got=%0d exp=%0d", r_op.y, int'(opa[exp]) * int'(opb[exp])); else passed++;
            checks++; if (r_op.id >= 0 && seen[r_op.id[1:0]]) $display("FAIL fair_repeat got=id%0d exp=unseen", r_op.id); else passed++;
            if (r_op.id >= 0) begin seen[r_op.id[1:0]] = 1'b1; cnt[r_op.id[1:0]]++; end
            last_ref = exp;
        end
        for (int k = 0; k < N; k++) begin
            checks++; if (cnt[k] != 2) $display("FAIL fair_count got=%0d exp=2 id=%0d", cnt[k], k); else passed++;
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_extremes();
        int exp;
        mul_lat = 8;
        opa[1] = 8'd255; opb[1] = 8'd255;
        opa[3] = 8'd0;   opb[3] = 8'd200;
        set_ops();
        req_i = 4'b0010;
        exp = rr_ref(req_i, last_ref);
        run_op(1'b0);
        checks++; if (r_op.id != exp || r_op.y != 65025) $display("FAIL extreme_max got=id%0d/%0d exp=id%0d/65025", r_op.id, r_op.y, exp); else passed++;
        last_ref = exp;
        req_i = 4'b1000;
        exp = rr_ref(req_i, last_ref);
        run_op(1'b0);
        checks++; if (r_op.id != exp || r_op.y != 0) $display("FAIL extreme_zero got=id%0d/%0d exp=id%0d/0", r_op.id, r_op.y, exp); else passed++;
        last_ref = exp;
    endtask

    task automatic test_random();
        logic [3:0] r;
        int exp, ey;
        for (int n = 0; n < 40; n++) begin
            r = 4'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                opa[k] = 8'($urandom_range(0, 255));
                opb[k] = 8'($urandom_range(0, 255));
            end
            set_ops();
            mul_lat = $urandom_range(1, 10);
            req_i = r;
            exp = rr_ref(r, last_ref);
            ey  = int'(opa[exp]) * int'(opb[exp]);
            run_op(1'($urandom_range(0, 1)));
            req_i = 4'd0;
            checks++; if (r_op.g != exp) $display("FAIL rand_grant got=%0d exp=%0d req=%b", r_op.g, exp, r); else passed++;
            checks++; if (r_op.id != exp || r_op.y != ey) $display("FAIL rand_result got=id%0d/%0d exp=id%0d/%0d", r_op.id, r_op.y, exp, ey); else passed++;
            checks++; if (r_op.lat != 3 + mul_lat) $display("FAIL rand_latency got=%0d exp=%0d", r_op.lat, 3 + mul_lat); else passed++;
            checks++; if (!r_op.stable || r_op.extra != 0) $display("FAIL rand_inflight got=stable%0d/extra%0d exp=stable1/extra0", r_op.stable, r_op.extra); else passed++;
            last_ref = exp;
        end
    endtask

    task automatic test_stuck();
        int exp;
        opa[2] = 8'd77; opb[2] = 8'd3;
        set_ops();
        mul_lat = 8;
        ignore_target = ignored_r + 1;
        req_i = 4'b0100;
        exp = rr_ref(req_i, last_ref);
        run_op(1'b0);
        checks++; if (r_op.starts != 2) $display("FAIL stuck_starts got=%0d exp=2", r_op.starts); else passed++;
        checks++; if (r_op.gap != 5) $display("FAIL stuck_gap got=%0d exp=5", r_op.gap); else passed++;
        checks++; if (r_op.lat != 16) $display("FAIL stuck_latency got=%0d exp=16", r_op.lat); else passed++;
        checks++; if (r_op.id != exp || r_op.y != 231) $display("FAIL stuck_result got=id%0d/%0d exp=id%0d/231", r_op.id, r_op.y, exp); else passed++;
        last_ref = exp;
        repeat (4) @(negedge clk_i);
        checks++; if (res_valid_o !== 1'b0) $display("FAIL stuck_single_result got=%b exp=0", res_valid_o); else passed++;
    endtask

    task automatic test_reset_mid();
        int idx, rv_seen, busy_gnt;
        bit gok, busy_after;
        mul_lat = 14;
        opa[0] = 8'd5; opb[0] = 8'd6;
        set_ops();
        req_i = 4'b0001;
        wait_grant(idx, gok);
        req_i = 4'd0;
        repeat (6) @(negedge clk_i);
        checks++; if (mult_busy_i !== 1'b1 || busy_o !== 1'b1) $display("FAIL rmid_in_wait got=%b/%b exp=1/1", mult_busy_i, busy_o); else passed++;
        rstn_i = 1'b0;
        #1;
        checks++; if ({gnt_o, res_valid_o, res_id_o, res_y_bo, busy_o, mult_start_o, mult_a_bo, mult_b_bo} !== 40'd0)
            $display("FAIL rmid_outputs got=%h exp=0", {gnt_o, res_valid_o, res_id_o, res_y_bo, busy_o, mult_start_o, mult_a_bo, mult_b_bo}); else passed++;
        @(negedge clk_i);
        rstn_i = 1'b1;
        last_ref = 3;
        mul_lat = 8;
        opa[1] = 8'd9; opb[1] = 8'd11;
        set_ops();
        req_i = 4'b0010;
        busy_after = mult_busy_i;
        rv_seen = 0; busy_gnt = 0; gok = 1'b0; idx = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (res_valid_o) rv_seen++;
            if (gnt_o != 4'd0) begin
                if (m_busy) busy_gnt++;
                for (int k = 0; k < N; k++) if (((gnt_o >> k) & 4'd1) != 4'd0) idx = k;
                gok = 1'b1;
                break;
            end
        end
        checks++; if (busy_after !== 1'b1) $display("FAIL rmid_mult_busy got=%b exp=1", busy_after); else passed++;
        checks++; if (!gok || busy_gnt != 0) $display("FAIL rmid_wait_idle got=granted%0d/while_busy%0d exp=1/0", gok, busy_gnt); else passed++;
        checks++; if (rv_seen != 0) $display("FAIL rmid_discard got=%0d exp=0", rv_seen); else passed++;
        r_op = '{g: idx, gv: gnt_o, id: -1, y: -1, lat: 0, starts: 0, gap: -1,
                 stable: 1'b1, extra: 0, ok: 1'b0};
        if (gok) finish_op(idx, 1'b0);
        checks++; if (r_op.g != 1 || r_op.id != 1 || r_op.y != 99) $display("FAIL rmid_next got=g%0d/id%0d/%0d exp=g1/id1/99", r_op.g, r_op.id, r_op.y); else passed++;
        checks++; if (r_op.lat != 11) $display("FAIL rmid_latency got=%0d exp=11", r_op.lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_extremes();
        test_random();
        test_stuck();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish (%0d/%0d so far)", passed, checks);
        $fatal(1);
    end

    // A second simultaneous grant bit is a failure whenever it occurs.
    always @(negedge clk_i) begin
        if (rstn_i && $countones(gnt_o) > 1) begin
            $display("FAIL gnt_onehot got=%b exp=onehot", gnt_o);
            $fatal(1);
        end
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter ID_W, default 2, meaning the requester-ID width, equal to clog2(N_REQ).
REQ-003 clk_i  input  1  clock; all logic rising-edge.
REQ-004 rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-005 req_i  input  N_REQ  per-requester request level.
REQ-006 a_bi  input  N_REQ*8  per-requester operand A; slice k belongs to requester k.
REQ-007 b_bi  input  N_REQ*8  per-requester operand B; slice k belongs to requester k.
REQ-008 gnt_o  output  N_REQ  one-hot pulse: operands of requester k captured this cycle.
REQ-009 res_valid_o  output  1  one-cycle pulse: result available.
REQ-010 res_id_o  output  ID_W  requester that owns the result.
REQ-011 res_y_bo  output  16  product.
REQ-012 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-013 mult_start_o  output  1  start strobe to the shared 8x8 sequential multiplier.
REQ-014 mult_a_bo, mult_b_bo  output  8 each  operands to the multiplier.
REQ-015 mult_busy_i  input  1  multiplier busy.
REQ-016 mult_y_bi  input  16  multiplier result.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and DELIVER.
REQ-018 IDLE with any req_i bit high: select the winner by round-robin, latch its a/b into mult_a_bo/mult_b_bo, pulse gnt_o[winner], store the ID, and go to ISSUE.
REQ-019 Round-robin search SHALL start at (last_served+1) mod N_REQ; after reset last_served = N_REQ-1, so requester 0 has first priority.
REQ-020 ISSUE: mult_start_o = 1 for exactly one cycle; next state WAIT_BUSY.
REQ-021 WAIT_BUSY: on mult_busy_i = 1, go to WAIT_DONE.
REQ-022 WAIT_BUSY timeout: if mult_busy_i stays 0 for 4 cycles, return to ISSUE and re-strobe; no result is emitted for that attempt.
REQ-023 WAIT_DONE: on mult_busy_i = 0, capture mult_y_bi into res_y_bo and go to DELIVER.
REQ-024 DELIVER: res_valid_o = 1 and res_id_o = stored ID for one cycle; update last_served; next state IDLE.
REQ-025 res_y_bo SHALL hold its value until the next capture.
REQ-026 mult_a_bo/mult_b_bo SHALL stay stable from grant until the transition out of WAIT_DONE.
REQ-027 Throughput: at most one operation in flight; no new grant before the return to IDLE.
REQ-028 A requester dropping req_i after its grant SHALL NOT cancel the operation; the result is still delivered.
REQ-029 A requester that keeps req_i high after its grant SHALL be re-arbitrated as a new request.
REQ-030 Simultaneous requests: exactly one gnt_o bit per grant; gnt_o SHALL never have more than one bit set.
REQ-031 Operands SHALL be unsigned; product = a*b, 16 bits, with no overflow possible.
REQ-032 Grant-to-res_valid_o latency = 3 + (multiplier busy length) cycles; 11 cycles with an 8-cycle multiplier.

Reset
REQ-033 rstn_i low SHALL asynchronously force state = IDLE and clear gnt_o, res_valid_o, res_id_o, res_y_bo, busy_o, mult_start_o, mult_a_bo and mult_b_bo to 0, with last_served = N_REQ-1.
REQ-034 Reset mid-operation SHALL discard the operation with no res_valid_o, even if mult_busy_i is still high after release.
REQ-035 After reset release, the block SHALL wait in IDLE for mult_busy_i = 0 before issuing.

Structure
REQ-036 The FSM state enum and the timeout constant (4) SHALL live in a shared package mult_pkg.
REQ-037 Winner selection SHALL be one sub-module, rr_picker (request vector + pointer -> one-hot grant + index), and SHALL be purely combinational.

Verification
REQ-038 Single request: req_i = 0001, a = 12, b = 13 -> gnt_o = 0001, then 11 cycles later res_valid_o with res_id_o = 0 and res_y_bo = 156.
REQ-039 All four requesting, operands k+2 and 10: grant order 0,1,2,3 -> results 20, 30, 40, 50 in that order.
REQ-040 Fairness: req_i = 1111 held for 8 operations -> each ID served exactly twice, and no ID is served twice before all four have been served.
REQ-041 Extremes: a = 255, b = 255 -> 65025; a = 0, b = 200 -> 0.
REQ-042 Stuck multiplier: mult_busy_i tied 0 for the first strobe -> mult_start_o re-pulses after 4 cycles; normal busy on the retry -> correct single result.
REQ-043 Reset in WAIT_DONE: rstn_i pulsed low -> all outputs 0 immediately, no res_valid_o; a subsequent request is served correctly.
